order_msg_serializer: RTL and testbench

- Sits directly downstream of the reverse parser. Takes its registered seven-word outgoing ADD-order message and serialises it into a 26-byte, big-endian, ITCH-style byte stream.
- The output is a valid/ready byte interface towards the exchange-side transmit MAC/FIFO.
- Single-message holding buffer. Messages arriving while a frame is in flight are dropped and counted; upstream can stall on o_busy.

---
 rtl/order_msg_serializer.sv | 137 +++++++++++++
 tb/tb_order_msg_serializer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/order_msg_serializer.sv
// rtl/order_msg_serializer.sv - serialises a seven-word ADD-order message into a 26-byte big-endian byte stream
module order_msg_serializer #(
  parameter int REG_WIDTH      = 32,
  parameter int IFG_CYCLES     = 2,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [REG_WIDTH-1:0]      i_reg_1,
  input  logic [REG_WIDTH-1:0]      i_reg_2,
  input  logic [REG_WIDTH-1:0]      i_reg_3,
  input  logic [REG_WIDTH-1:0]      i_reg_4,
  input  logic [REG_WIDTH-1:0]      i_reg_5,
  input  logic [REG_WIDTH-1:0]      i_reg_6,
  input  logic [REG_WIDTH-1:0]      i_reg_7,
  input  logic                      i_valid,
  output logic                      o_busy,
  output logic [7:0]                o_tdata,
  output logic                      o_tvalid,
  input  logic                      i_tready,
  output logic                      o_tfirst,
  output logic                      o_tlast,
  output logic [15:0]               o_sent_cnt,
  output logic [DROP_CNT_WIDTH-1:0] o_drop_cnt
);

  localparam int         FRAME_BYTES = 26;
  localparam int         FRAME_BITS  = 8 * FRAME_BYTES;
  localparam logic [4:0] LAST_IDX    = 5'd25;
  localparam int         GAP_W       = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int         GAP_LAST    = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t                   state;
  state_t                   next_state;
  logic [4:0]               byte_idx;
  logic [GAP_W-1:0]         gap_cnt;
  logic [7:0]               buf_type;
  logic                     buf_sell;
  logic [6*REG_WIDTH-1:0]   buf_words;
  logic [FRAME_BITS-1:0]    frame;
  logic [7:0]               cur_byte;
  logic                     accept;
  logic                     handshake;
  logic                     frame_done;
  logic                     unused_reg_1_hi;

  // Only the type and side bits of word 1 are carried on the wire.
  assign unused_reg_1_hi = ^i_reg_1[REG_WIDTH-1:9];

  assign handshake  = (state == S_SEND) && i_tready;
  assign frame_done = handshake && (byte_idx == LAST_IDX);

  // State register; async reset aborts any frame in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state decode: accept only from IDLE, leave SEND on the last handshake.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_valid) begin
          accept     = 1'b1;
          next_state = S_SEND;
        end
      end
      S_SEND: begin
        if (frame_done) next_state = (IFG_CYCLES > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (gap_cnt == GAP_W'(GAP_LAST)) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Holding buffer loads only when a message is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_type  <= '0;
      buf_sell  <= 1'b0;
      buf_words <= '0;
    end else if (accept) begin
      buf_type  <= i_reg_1[8:1];
      buf_sell  <= i_reg_1[0];
      buf_words <= {i_reg_2, i_reg_3, i_reg_4, i_reg_5, i_reg_6, i_reg_7};
    end
  end

  // Byte index advances on each accepted byte and rewinds for the next frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        byte_idx <= '0;
    else if (accept)     byte_idx <= '0;
    else if (frame_done) byte_idx <= '0;
    else if (handshake)  byte_idx <= byte_idx + 5'd1;
  end

  // Inter-frame gap counter runs only while in GAP.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)            gap_cnt <= '0;
    else if (state == S_GAP) gap_cnt <= gap_cnt + GAP_W'(1);
    else                     gap_cnt <= '0;
  end

  // Completed-frame counter wraps; drop counter saturates at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sent_cnt <= '0;
      o_drop_cnt <= '0;
    end else begin
      if (frame_done) o_sent_cnt <= o_sent_cnt + 16'd1;
      if (i_valid && (state != S_IDLE) && (o_drop_cnt != {DROP_CNT_WIDTH{1'b1}}))
        o_drop_cnt <= o_drop_cnt + DROP_CNT_WIDTH'(1);
    end
  end

  // Big-endian frame image and byte select; everything here is from registers.
  always_comb begin
    frame    = {buf_type, (buf_sell ? 8'h53 : 8'h42), buf_words};
    cur_byte = 8'h00;
    for (int i = 0; i < FRAME_BYTES; i++) begin
      if (byte_idx == 5'(i)) cur_byte = frame[FRAME_BITS-1-8*i -: 8];
    end
  end

  assign o_tvalid = (state == S_SEND);
  assign o_busy   = (state != S_IDLE);
  assign o_tdata  = o_tvalid ? cur_byte : 8'h00;
  assign o_tfirst = o_tvalid && (byte_idx == 5'd0);
  assign o_tlast  = o_tvalid && (byte_idx == LAST_IDX);

endmodule

// File: tb/tb_order_msg_serializer.sv
// tb/tb_order_msg_serializer.sv - scoreboard bench for order_msg_serializer with a reference model
module tb_order_msg_serializer;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic        i_rst_n;
  logic        i_valid;
  logic        i_tready;
  logic [31:0] rw [7];

  logic        busy0, tvalid0, tfirst0, tlast0;
  logic [7:0]  tdata0;
  logic [15:0] sent0, drop0;
  logic        busy1, tvalid1, tfirst1, tlast1;
  logic [7:0]  tdata1;
  logic [15:0] sent1;
  logic [1:0]  drop1;

  order_msg_serializer #(.REG_WIDTH(32), .IFG_CYCLES(2), .DROP_CNT_WIDTH(16)) u_dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_reg_1(rw[0]), .i_reg_2(rw[1]), .i_reg_3(rw[2]), .i_reg_4(rw[3]),
    .i_reg_5(rw[4]), .i_reg_6(rw[5]), .i_reg_7(rw[6]),
    .i_valid(i_valid), .o_busy(busy0), .o_tdata(tdata0), .o_tvalid(tvalid0),
    .i_tready(i_tready), .o_tfirst(tfirst0), .o_tlast(tlast0),
    .o_sent_cnt(sent0), .o_drop_cnt(drop0)
  );

  order_msg_serializer #(.REG_WIDTH(32), .IFG_CYCLES(0), .DROP_CNT_WIDTH(2)) u_dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_reg_1(rw[0]), .i_reg_2(rw[1]), .i_reg_3(rw[2]), .i_reg_4(rw[3]),
    .i_reg_5(rw[4]), .i_reg_6(rw[5]), .i_reg_7(rw[6]),
    .i_valid(i_valid), .o_busy(busy1), .o_tdata(tdata1), .o_tvalid(tvalid1),
    .i_tready(i_tready), .o_tfirst(tfirst1), .o_tlast(tlast1),
    .o_sent_cnt(sent1), .o_drop_cnt(drop1)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       first;
    logic       last;
  } exp_t;

  localparam int IFG  [2] = '{2, 0};
  localparam int DMAX [2] = '{65535, 3};
  localparam logic [7:0] EXP_BASIC [26] = '{
    8'h0A, 8'h42, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h03, 8'hBA,
    8'h00, 8'h00, 8'h01, 8'hBB, 8'h41, 8'h41, 8'h50, 8'h4C, 8'h20, 8'h20,
    8'h20, 8'h20, 8'h00, 8'h00, 8'hBA, 8'hBB};

  exp_t        q0[$];
  exp_t        q1[$];
  logic [7:0]  cap0[$];
  int          passed = 0;
  int          total  = 0;

  // Reference model: busy windows measured in bytes owed and quiet cycles left.
  int          sending   [2] = '{0, 0};
  int          owed      [2] = '{0, 0};
  int          quiet     [2] = '{0, 0};
  logic [15:0] sent_m    [2] = '{16'd0, 16'd0};
  int          drop_m    [2] = '{0, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic model_accept(input int d);
    logic [7:0] b [26];
    exp_t e;
    b[0] = rw[0][8:1];
    b[1] = rw[0][0] ? 8'h53 : 8'h42;
    for (int w = 0; w < 6; w++)
      for (int j = 0; j < 4; j++)
        b[2 + 4*w + j] = 8'((rw[w+1] >> (24 - 8*j)) & 32'hFF);
    for (int i = 0; i < 26; i++) begin
      e.data  = b[i];
      e.first = (i == 0);
      e.last  = (i == 25);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic model_step(input int d);
    if (sending[d] == 0 && quiet[d] == 0) begin
      if (i_valid) begin
        model_accept(d);
        sending[d] = 1;
        owed[d]    = 26;
      end
    end else begin
      if (i_valid && drop_m[d] < DMAX[d]) drop_m[d]++;
      if (sending[d] == 1) begin
        if (i_tready) begin
          owed[d]--;
          if (owed[d] == 0) begin
            sent_m[d]  = sent_m[d] + 16'd1;
            sending[d] = 0;
            quiet[d]   = IFG[d];
          end
        end
      end else begin
        quiet[d]--;
      end
    end
  endtask

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int d = 0; d < 2; d++) begin
        sending[d] = 0; owed[d] = 0; quiet[d] = 0; sent_m[d] = 16'd0; drop_m[d] = 0;
      end
      q0.delete();
      q1.delete();
    end else begin
      for (int d = 0; d < 2; d++) model_step(d);
    end
  end

  task automatic mon(input int d, input logic tv, input logic bz, input logic [7:0] td,
                     input logic tf, input logic tl, input logic [15:0] sc, input logic [15:0] dc);
    exp_t e;
    chk($sformatf("d%0d_tvalid", d), 32'(tv), 32'(sending[d] == 1));
    chk($sformatf("d%0d_busy", d), 32'(bz), 32'(sending[d] == 1 || quiet[d] > 0));
    chk($sformatf("d%0d_sent_cnt", d), 32'(sc), 32'(sent_m[d]));
    chk($sformatf("d%0d_drop_cnt", d), 32'(dc), 32'(drop_m[d]));
    if (tv && i_tready) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        chk($sformatf("d%0d_unexpected_byte", d), 32'(td), 32'hFFFF_FFFF);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("d%0d_tdata", d), 32'(td), 32'(e.data));
        chk($sformatf("d%0d_tfirst", d), 32'(tf), 32'(e.first));
        chk($sformatf("d%0d_tlast", d), 32'(tl), 32'(e.last));
      end
      if (d == 0) cap0.push_back(td);
    end
  endtask

  // Monitor: compares every cycle, away from the active edge.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      mon(0, tvalid0, busy0, tdata0, tfirst0, tlast0, sent0, drop0);
      mon(1, tvalid1, busy1, tdata1, tfirst1, tlast1, sent1, {14'd0, drop1});
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_in();
    i_valid = 1'b0;
    for (int i = 0; i < 7; i++) rw[i] = 32'd0;
  endtask

  task automatic load_basic(input logic [31:0] r1);
    i_valid = 1'b1;
    rw[0] = r1;          rw[1] = 32'h300;       rw[2] = 32'h3BA; rw[3] = 32'h1BB;
    rw[4] = 32'h4141504C; rw[5] = 32'h20202020; rw[6] = 32'hBABB;
  endtask

  task automatic load_random();
    i_valid = 1'b1;
    for (int i = 0; i < 7; i++) rw[i] = $urandom;
  endtask

  task automatic check_cap(input string nm, input logic [7:0] byte1);
    logic [7:0] want;
    chk({nm, "_len"}, 32'(cap0.size()), 32'd26);
    for (int i = 0; i < 26 && i < cap0.size(); i++) begin
      want = (i == 1) ? byte1 : EXP_BASIC[i];
      chk($sformatf("%s_byte%0d", nm, i), 32'(cap0[i]), 32'(want));
    end
  endtask

  initial begin
    int          found;
    logic [15:0] s1;
    i_rst_n  = 1'b0;
    i_tready = 1'b0;
    idle_in();
    repeat (3) tick();
    chk("rst_tvalid0", 32'(tvalid0), 32'd0);
    chk("rst_tdata0",  32'(tdata0),  32'd0);
    chk("rst_tfirst0", 32'(tfirst0), 32'd0);
    chk("rst_tlast0",  32'(tlast0),  32'd0);
    chk("rst_busy0",   32'(busy0),   32'd0);
    chk("rst_sent0",   32'(sent0),   32'd0);
    chk("rst_drop0",   32'(drop0),   32'd0);
    chk("rst_tvalid1", 32'(tvalid1), 32'd0);
    chk("rst_drop1",   32'(drop1),   32'd0);
    i_rst_n = 1'b1;
    tick();

    // Basic frame with the ready line held high.
    i_tready = 1'b1;
    cap0.delete();
    load_basic(32'h014);
    tick();
    idle_in();
    repeat (34) tick();
    check_cap("basic", 8'h42);
    chk("basic_sent0", 32'(sent0), 32'd1);

    // Backpressure: ready pattern 1,0,0,1 repeating, SELL side.
    cap0.delete();
    for (int k = 0; k < 120; k++) begin
      if (k == 0) load_basic(32'h015);
      else        idle_in();
      i_tready = (k % 4 == 0) || (k % 4 == 3);
      tick();
    end
    i_tready = 1'b1;
    check_cap("bp", 8'h53);

    // Drops at +5 and on the byte-25 handshake cycle, then saturation.
    for (int k = 0; k < 41; k++) begin
      if (k == 0 || k == 5 || k == 26) load_random();
      else                             idle_in();
      tick();
    end
    idle_in();
    repeat (5) tick();
    chk("drop0_two", 32'(drop0), 32'd2);
    chk("drop1_two", 32'(drop1), 32'd2);
    for (int k = 0; k < 36; k++) begin
      if (k == 0 || k == 3 || k == 6 || k == 9) load_random();
      else                                      idle_in();
      tick();
    end
    idle_in();
    repeat (4) tick();
    chk("drop0_five", 32'(drop0), 32'd5);
    chk("drop1_sat",  32'(drop1), 32'd3);

    // Back-to-back on the zero-gap instance: one idle cycle between frames.
    s1 = sent1;
    for (int k = 0; k < 60; k++) begin
      if (k == 26) chk("b2b_tlast1_k26",  32'(tlast1),  32'd1);
      if (k == 27) chk("b2b_tvalid1_k27", 32'(tvalid1), 32'd0);
      if (k == 28) chk("b2b_tfirst1_k28", 32'(tfirst1), 32'd1);
      if (k == 0 || k == 27) load_random();
      else                   idle_in();
      tick();
    end
    chk("b2b_sent1", 32'(sent1), 32'(s1 + 16'd2));

    // Randomised traffic and ready.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(15, 0) == 0) load_random();
      else                            idle_in();
      i_tready = ($urandom_range(3, 0) != 0);
      tick();
    end
    idle_in();
    i_tready = 1'b1;
    repeat (40) tick();

    // Asynchronous reset while byte 12 is on the bus.
    load_basic(32'h014);
    tick();
    idle_in();
    found = 0;
    for (int k = 0; k < 60; k++) begin
      if (sending[0] == 1 && q0.size() == 14) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("rst_mid_reached", 32'(found), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid_tvalid0", 32'(tvalid0), 32'd0);
    chk("rst_mid_tlast0",  32'(tlast0),  32'd0);
    chk("rst_mid_busy0",   32'(busy0),   32'd0);
    chk("rst_mid_sent0",   32'(sent0),   32'd0);
    chk("rst_mid_drop0",   32'(drop0),   32'd0);
    chk("rst_mid_tvalid1", 32'(tvalid1), 32'd0);
    chk("rst_mid_sent1",   32'(sent1),   32'd0);
    chk("rst_mid_drop1",   32'(drop1),   32'd0);
    repeat (2) tick();
    i_rst_n = 1'b1;
    tick();
    cap0.delete();
    load_basic(32'h014);
    tick();
    idle_in();
    repeat (34) tick();
    check_cap("post_rst", 8'h42);
    chk("post_rst_sent0", 32'(sent0), 32'd1);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
